// File: rtl/stream_packer.sv
// stream_packer: packs ratio_p consecutive width_p-bit stream words into one
// (ratio_p*width_p)-bit word. Lane 0 is the least significant lane. The output
// side is a registered valid/ready stage that holds its word while the
// consumer stalls.
// Optional feature macro: STREAM_PACKER_LAST_EN adds last_i / keep_o. With it,
// a word accepted with last_i=1 closes a partial word. Unfilled lanes are zero
// and are masked off in keep_o.
module stream_packer #(
  parameter int width_p = 8,
  parameter int ratio_p = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [width_p-1:0]           data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [ratio_p*width_p-1:0]   data_o,
  output logic                         valid_o,
`ifdef STREAM_PACKER_LAST_EN
  input  logic                         last_i,
  output logic [ratio_p-1:0]           keep_o,
`endif
  input  logic                         ready_i
);

  localparam int CNT_W = (ratio_p > 1) ? $clog2(ratio_p) : 1;
  localparam int OUT_W = ratio_p * width_p;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(ratio_p - 1);

  // Lane counter, assembly buffer and registered output stage.
  logic [CNT_W-1:0]   r_count;
  logic [OUT_W-1:0]   r_asm;
  logic [OUT_W-1:0]   r_data;
  logic               r_valid;
`ifdef STREAM_PACKER_LAST_EN
  logic [ratio_p-1:0] r_keep;
  logic [ratio_p-1:0] w_keep_next;
`endif

  logic               w_last;
  logic               w_final_lane;
  logic               w_ready;
  logic               w_accept;
  logic               w_complete;
  logic               w_consume;
  logic [OUT_W-1:0]   w_asm_next;

`ifdef STREAM_PACKER_LAST_EN
  assign w_last = last_i;
`else
  assign w_last = 1'b0;
`endif

  // Only a completing word can be back-pressured. A completing word is the
  // one that fills the top lane, or one marked last. Every other lane keeps
  // filling while the output is held.
  assign w_final_lane = (r_count == LAST_LANE);
  assign w_ready      = (~w_final_lane & ~w_last) | ~r_valid | ready_i;
  assign w_accept     = valid_i & w_ready;
  assign w_complete   = w_accept & (w_final_lane | w_last);
  assign w_consume    = r_valid & ready_i;

  // Assembly buffer with the incoming word merged into the current lane.
  always_comb begin
    w_asm_next = r_asm;
    for (int k = 0; k < ratio_p; k++) begin
      if (k == int'(r_count)) begin
        w_asm_next[k*width_p +: width_p] = data_i;
      end else begin
        w_asm_next[k*width_p +: width_p] = r_asm[k*width_p +: width_p];
      end
    end
  end

`ifdef STREAM_PACKER_LAST_EN
  // Lane mask for a word that completes now: lanes 0..r_count are filled.
  always_comb begin
    w_keep_next = {ratio_p{1'b0}};
    for (int k = 0; k < ratio_p; k++) begin
      if (k <= int'(r_count)) begin
        w_keep_next[k] = 1'b1;
      end else begin
        w_keep_next[k] = 1'b0;
      end
    end
  end
`endif

  // Fill lanes on accept, hand complete words to the output stage, retire on consume.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_count <= {CNT_W{1'b0}};
      r_asm   <= {OUT_W{1'b0}};
      r_data  <= {OUT_W{1'b0}};
      r_valid <= 1'b0;
`ifdef STREAM_PACKER_LAST_EN
      r_keep  <= {ratio_p{1'b0}};
`endif
    end else if (w_complete) begin
      // Completion wins over a same-cycle consume so back-to-back words
      // stream without a bubble. The assembly buffer is cleared so that lanes
      // left unfilled by an early last word read as zero.
      r_data  <= w_asm_next;
      r_valid <= 1'b1;
      r_asm   <= {OUT_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
`ifdef STREAM_PACKER_LAST_EN
      r_keep  <= w_keep_next;
`endif
    end else begin
      if (w_accept) begin
        r_asm   <= w_asm_next;
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_asm   <= r_asm;
        r_count <= r_count;
      end
      // data_o keeps its stale value after a consume; only valid drops.
      if (w_consume) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign ready_o = w_ready;
  assign data_o  = r_data;
  assign valid_o = r_valid;
`ifdef STREAM_PACKER_LAST_EN
  assign keep_o  = r_keep;
`endif

endmodule
